// File: rtl/l2_pkg.sv
// Shared definitions for the L2 cache controller: FSM states, request-source
// encodings and the default memory-handshake watchdog limit.
package l2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CHKDIRTY,
        ST_WB,
        ST_REFILL_REQ,
        ST_REFILL_WAIT,
        ST_MERGE_WR,
        ST_SUC_WR
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_IR   = 2'b01;
    localparam logic [1:0] SRC_DR   = 2'b10;
    localparam logic [1:0] SRC_DW   = 2'b11;

    localparam int TMO_DEFAULT = 1023;

    // States in which the controller is blocked on the memory side
    function automatic logic mem_wait_state(input state_t s);
        return (s == ST_WB) || (s == ST_REFILL_REQ) ||
               (s == ST_REFILL_WAIT) || (s == ST_SUC_WR);
    endfunction

endpackage

// File: rtl/l2_prio_enc.sv
// Lowest-index priority encoder for the per-way tag-match vector, with an
// "any" flag and a flag for more than one bit set.
module l2_prio_enc #(
    parameter int WAY   = 4,
    parameter int WAY_W = $clog2(WAY)
) (
    input  logic [WAY-1:0]   vec,
    output logic [WAY_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    logic [WAY-1:0] lowest;

    genvar gi;
    generate
        for (gi = 0; gi < WAY; gi++) begin : g_lowest
            if (gi == 0) begin : g_first
                assign lowest[gi] = vec[0];
            end else begin : g_rest
                assign lowest[gi] = vec[gi] & ~(|vec[gi-1:0]);
            end
        end
    endgenerate

    // lowest is one-hot (or zero), so OR-ing the indices yields the encoding
    always_comb begin
        idx = '0;
        for (int i = 0; i < WAY; i++) begin
            if (lowest[i]) begin
                idx = idx | WAY_W'(i);
            end
        end
    end

    assign any   = |vec;
    assign multi = |(vec & (vec - WAY'(1)));

endmodule

// File: rtl/l2cache_fsm_param.sv
// L2 cache control FSM: lookup, dirty-victim writeback, refill, write merge and
// strongly-ordered bypass, with saturating hit/miss counters and sticky errors.
module l2cache_fsm_param
    import l2_pkg::*;
#(
    parameter int WAY   = 4,
    parameter int WAY_W = $clog2(WAY),
    parameter int CNT_W = 32,
    parameter int TMO   = TMO_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    input  logic [1:0]       req_src,
    input  logic             req_suc,
    output logic             req_ready,
    input  logic [WAY-1:0]   hit,
    input  logic [WAY_W-1:0] victim_way,
    input  logic             victim_dirty,
    output logic             mem_req_r,
    output logic             mem_req_w,
    output logic             mem_rdy,
    input  logic             mem_addr_ok_r,
    input  logic             mem_addr_ok_w,
    input  logic             mem_data_ok,
    output logic             icache_data_ok,
    output logic             dcache_data_ok,
    output logic [WAY-1:0]   data_we,
    output logic             data_replace,
    output logic             wb_read,
    output logic [WAY-1:0]   use_way,
    output logic [WAY_W-1:0] dirty_way,
    output logic             dirty_set,
    output logic             dirty_clr,
    output logic [WAY_W-1:0] choose_way,
    output logic             choose_return,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             err_multihit,
    output logic             err_timeout,
    output logic             busy
);

    localparam int WD_W = $clog2(TMO + 1);

    state_t           state_reg;
    state_t           state_next;
    logic [1:0]       src_reg;
    logic             suc_reg;
    logic [WAY_W-1:0] vway_reg;
    logic [WD_W-1:0]  wdog_reg;
    logic [CNT_W-1:0] hit_cnt_reg;
    logic [CNT_W-1:0] miss_cnt_reg;
    logic             err_multihit_reg;
    logic             err_timeout_reg;

    logic [WAY_W-1:0] hit_idx;
    logic             hit_any;
    logic             hit_multi;
    logic [WAY-1:0]   hit_mask;
    logic [WAY-1:0]   vway_mask;
    logic             l1_ack;
    logic             lookup_hit;
    logic             lookup_miss;
    logic             src_write;

    l2_prio_enc #(
        .WAY   (WAY),
        .WAY_W (WAY_W)
    ) u_hit_enc (
        .vec   (hit),
        .idx   (hit_idx),
        .any   (hit_any),
        .multi (hit_multi)
    );

    assign hit_mask    = WAY'(1) << hit_idx;
    assign vway_mask   = WAY'(1) << vway_reg;
    assign src_write   = (src_reg == SRC_DW);
    assign lookup_hit  = (state_reg == ST_LOOKUP) && !suc_reg && hit_any;
    assign lookup_miss = (state_reg == ST_LOOKUP) && !suc_reg && !hit_any;

    always_comb begin
        state_next    = state_reg;
        req_ready     = 1'b0;
        mem_req_r     = 1'b0;
        mem_req_w     = 1'b0;
        mem_rdy       = 1'b0;
        l1_ack        = 1'b0;
        data_we       = '0;
        data_replace  = 1'b0;
        wb_read       = 1'b0;
        use_way       = '0;
        dirty_way     = '0;
        dirty_set     = 1'b0;
        dirty_clr     = 1'b0;
        choose_way    = '0;
        choose_return = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Gated by rstn so nothing is accepted while reset is held
                if (rstn && req_valid && (req_src != SRC_NONE)) begin
                    req_ready  = 1'b1;
                    state_next = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                if (suc_reg) begin
                    state_next = src_write ? ST_SUC_WR : ST_REFILL_REQ;
                end else if (hit_any) begin
                    use_way = hit_mask;
                    if (src_write) begin
                        data_we   = hit_mask;
                        dirty_way = hit_idx;
                        dirty_set = 1'b1;
                    end else begin
                        choose_way = hit_idx;
                        l1_ack     = 1'b1;
                    end
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_CHKDIRTY;
                end
            end

            ST_CHKDIRTY: begin
                wb_read    = 1'b1;
                dirty_way  = vway_reg;
                state_next = victim_dirty ? ST_WB : ST_REFILL_REQ;
            end

            ST_WB: begin
                mem_req_w  = 1'b1;
                choose_way = vway_reg;
                wb_read    = 1'b1;
                if (mem_addr_ok_w) begin
                    state_next = ST_REFILL_REQ;
                end
            end

            ST_REFILL_REQ: begin
                mem_req_r = 1'b1;
                if (mem_addr_ok_r || mem_data_ok) begin
                    state_next = ST_REFILL_WAIT;
                end
            end

            ST_REFILL_WAIT: begin
                mem_rdy = 1'b1;
                if (mem_data_ok) begin
                    choose_return = 1'b1;
                    if (suc_reg) begin
                        l1_ack     = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        data_replace = 1'b1;
                        data_we      = vway_mask;
                        if (src_write) begin
                            state_next = ST_MERGE_WR;
                        end else begin
                            use_way    = vway_mask;
                            dirty_way  = vway_reg;
                            dirty_clr  = 1'b1;
                            l1_ack     = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                end
            end

            ST_MERGE_WR: begin
                data_we    = vway_mask;
                use_way    = vway_mask;
                dirty_way  = vway_reg;
                dirty_set  = 1'b1;
                state_next = ST_IDLE;
            end

            ST_SUC_WR: begin
                mem_req_w = 1'b1;
                if (mem_addr_ok_w) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign icache_data_ok = l1_ack && (src_reg == SRC_IR);
    assign dcache_data_ok = l1_ack && (src_reg == SRC_DR);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= ST_IDLE;
            src_reg          <= SRC_NONE;
            suc_reg          <= 1'b0;
            vway_reg         <= '0;
            wdog_reg         <= '0;
            hit_cnt_reg      <= '0;
            miss_cnt_reg     <= '0;
            err_multihit_reg <= 1'b0;
            err_timeout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (req_ready) begin
                src_reg <= req_src;
                suc_reg <= req_suc;
            end

            if (lookup_hit) begin
                if (hit_cnt_reg != '1) begin
                    hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
                end
                if (hit_multi) begin
                    err_multihit_reg <= 1'b1;
                end
            end

            if (lookup_miss) begin
                vway_reg <= victim_way;
                if (miss_cnt_reg != '1) begin
                    miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
                end
            end

            // Watchdog only flags a stall; the handshake is never abandoned
            if (state_next != state_reg) begin
                wdog_reg <= '0;
            end else if (mem_wait_state(state_reg) && (wdog_reg != WD_W'(TMO))) begin
                wdog_reg <= wdog_reg + WD_W'(1);
                if ((wdog_reg + WD_W'(1)) == WD_W'(TMO)) begin
                    err_timeout_reg <= 1'b1;
                end
            end
        end
    end

    assign hit_cnt      = hit_cnt_reg;
    assign miss_cnt     = miss_cnt_reg;
    assign err_multihit = err_multihit_reg;
    assign err_timeout  = err_timeout_reg;
    assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_l2cache_fsm_param.sv
// Randomized bench for l2cache_fsm_param: a transaction-level model predicts
// every cycle's outputs, plus directed scenarios with literal expectations.
module tb_l2cache_fsm_param;
    import l2_pkg::*;

    localparam int WAY     = 8;
    localparam int WAY_W   = 3;
    localparam int CNT_W   = 4;
    localparam int TMO     = 60;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int PH_WB    = 0;
    localparam int PH_SUCW  = 1;
    localparam int PH_RREQ  = 2;
    localparam int PH_RWAIT = 3;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             req_valid = 1'b0;
    logic [1:0]       req_src = 2'b00;
    logic             req_suc = 1'b0;
    logic             req_ready;
    logic [WAY-1:0]   hit = '0;
    logic [WAY_W-1:0] victim_way = '0;
    logic             victim_dirty = 1'b0;
    logic             mem_req_r, mem_req_w, mem_rdy;
    logic             mem_addr_ok_r = 1'b0, mem_addr_ok_w = 1'b0, mem_data_ok = 1'b0;
    logic             icache_data_ok, dcache_data_ok;
    logic [WAY-1:0]   data_we;
    logic             data_replace, wb_read;
    logic [WAY-1:0]   use_way;
    logic [WAY_W-1:0] dirty_way;
    logic             dirty_set, dirty_clr;
    logic [WAY_W-1:0] choose_way;
    logic             choose_return;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;
    logic             err_multihit, err_timeout, busy;

    always #5 clk = ~clk;

    l2cache_fsm_param #(
        .WAY   (WAY),
        .WAY_W (WAY_W),
        .CNT_W (CNT_W),
        .TMO   (TMO)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_src        (req_src),
        .req_suc        (req_suc),
        .req_ready      (req_ready),
        .hit            (hit),
        .victim_way     (victim_way),
        .victim_dirty   (victim_dirty),
        .mem_req_r      (mem_req_r),
        .mem_req_w      (mem_req_w),
        .mem_rdy        (mem_rdy),
        .mem_addr_ok_r  (mem_addr_ok_r),
        .mem_addr_ok_w  (mem_addr_ok_w),
        .mem_data_ok    (mem_data_ok),
        .icache_data_ok (icache_data_ok),
        .dcache_data_ok (dcache_data_ok),
        .data_we        (data_we),
        .data_replace   (data_replace),
        .wb_read        (wb_read),
        .use_way        (use_way),
        .dirty_way      (dirty_way),
        .dirty_set      (dirty_set),
        .dirty_clr      (dirty_clr),
        .choose_way     (choose_way),
        .choose_return  (choose_return),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt),
        .err_multihit   (err_multihit),
        .err_timeout    (err_timeout),
        .busy           (busy)
    );

    typedef struct packed {
        logic             req_ready;
        logic             mem_req_r;
        logic             mem_req_w;
        logic             mem_rdy;
        logic             ic_ok;
        logic             dc_ok;
        logic [WAY-1:0]   data_we;
        logic             data_replace;
        logic             wb_read;
        logic [WAY-1:0]   use_way;
        logic [WAY_W-1:0] dirty_way;
        logic             dirty_set;
        logic             dirty_clr;
        logic [WAY_W-1:0] choose_way;
        logic             choose_return;
        logic [CNT_W-1:0] hit_cnt;
        logic [CNT_W-1:0] miss_cnt;
        logic             err_mh;
        logic             err_to;
        logic             busy;
    } out_t;

    out_t act, exp_o, snap, lk_snap, refill_snap, merge_snap;
    logic exp_valid = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Model state: counters and sticky flags as the specification describes them
    int   hc_m = 0;
    int   mc_m = 0;
    logic mh_m = 1'b0;
    logic to_m = 1'b0;

    assign act = {req_ready, mem_req_r, mem_req_w, mem_rdy, icache_data_ok, dcache_data_ok,
                  data_we, data_replace, wb_read, use_way, dirty_way, dirty_set, dirty_clr,
                  choose_way, choose_return, hit_cnt, miss_cnt, err_multihit, err_timeout, busy};

    always @(negedge clk) begin
        if (exp_valid) begin
            n_checks++;
            if (act !== exp_o) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h diff=%h",
                         $time, act, exp_o, act ^ exp_o);
            end
        end
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL global_time_limit reached actual=running required=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] r);
        n_checks++;
        if (a !== r) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, a, r);
        end
    endtask

    function automatic int sat(input int c);
        return (c < CNT_MAX) ? c + 1 : c;
    endfunction

    function automatic int lowest_set(input logic [WAY-1:0] v);
        int r = 0;
        for (int i = WAY - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    function automatic out_t base(input logic b);
        out_t e;
        e          = '0;
        e.hit_cnt  = CNT_W'(hc_m);
        e.miss_cnt = CNT_W'(mc_m);
        e.err_mh   = mh_m;
        e.err_to   = to_m;
        e.busy     = b;
        return e;
    endfunction

    task automatic noise();
        req_valid     = 1'($urandom);
        req_src       = 2'($urandom);
        req_suc       = 1'($urandom);
        hit           = 8'($urandom);
        victim_way    = 3'($urandom);
        victim_dirty  = 1'($urandom);
        mem_addr_ok_r = 1'($urandom);
        mem_addr_ok_w = 1'($urandom);
        mem_data_ok   = 1'($urandom);
    endtask

    // One clock cycle: publish the expectation, sample at the falling edge
    task automatic cycle(input out_t e);
        exp_o     = e;
        exp_valid = 1'b1;
        @(negedge clk);
        snap = act;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            if (req_valid) req_src = SRC_NONE;
            cycle(base(1'b0));
        end
    endtask

    task automatic wait_phase(input int kind, input int d, input logic [2:0] vw,
                              input logic [1:0] src, input logic suc);
        out_t       e;
        logic [7:0] vm;
        vm = 8'(1) << vw;
        for (int k = 0; k <= d; k++) begin
            noise();
            e = base(1'b1);
            case (kind)
                PH_WB: begin
                    mem_addr_ok_w = (k == d);
                    e.mem_req_w   = 1'b1;
                    e.choose_way  = vw;
                    e.wb_read     = 1'b1;
                end
                PH_SUCW: begin
                    mem_addr_ok_w = (k == d);
                    e.mem_req_w   = 1'b1;
                end
                PH_RREQ: begin
                    mem_addr_ok_r = (k == d);
                    mem_data_ok   = 1'b0;
                    e.mem_req_r   = 1'b1;
                end
                default: begin
                    mem_data_ok = (k == d);
                    e.mem_rdy   = 1'b1;
                    if (k == d) begin
                        e.choose_return = 1'b1;
                        if (suc) begin
                            e.ic_ok = (src == SRC_IR);
                            e.dc_ok = (src == SRC_DR);
                        end else begin
                            e.data_replace = 1'b1;
                            e.data_we      = vm;
                            if (src != SRC_DW) begin
                                e.use_way   = vm;
                                e.dirty_way = vw;
                                e.dirty_clr = 1'b1;
                                e.ic_ok     = (src == SRC_IR);
                                e.dc_ok     = (src == SRC_DR);
                            end
                        end
                    end
                end
            endcase
            cycle(e);
            // Stalled for TMO cycles in one memory-wait state -> sticky timeout
            if (k < d && k + 1 == TMO) to_m = 1'b1;
        end
        if (kind == PH_RWAIT) refill_snap = snap;
    endtask

    task automatic txn(input logic [1:0] src, input logic suc, input logic [7:0] hv,
                       input logic [2:0] vw, input logic vd,
                       input int dw, input int dr, input int dd);
        out_t e;
        int   idx;
        lk_snap     = '0;
        refill_snap = '0;
        merge_snap  = '0;

        noise();
        req_valid   = 1'b1;
        req_src     = src;
        req_suc     = suc;
        e           = base(1'b0);
        e.req_ready = 1'b1;
        cycle(e);

        noise();
        hit        = hv;
        victim_way = vw;
        e          = base(1'b1);
        if (!suc && hv != 8'h00) begin
            idx       = lowest_set(hv);
            e.use_way = 8'(1) << idx;
            if (src == SRC_DW) begin
                e.data_we   = e.use_way;
                e.dirty_way = 3'(idx);
                e.dirty_set = 1'b1;
            end else begin
                e.choose_way = 3'(idx);
                e.ic_ok      = (src == SRC_IR);
                e.dc_ok      = (src == SRC_DR);
            end
            cycle(e);
            lk_snap = snap;
            hc_m    = sat(hc_m);
            if ($countones(hv) > 1) mh_m = 1'b1;
            return;
        end
        cycle(e);
        lk_snap = snap;

        if (suc && src == SRC_DW) begin
            wait_phase(PH_SUCW, dw, vw, src, suc);
            return;
        end

        if (!suc) begin
            mc_m = sat(mc_m);
            noise();
            victim_dirty = vd;
            e            = base(1'b1);
            e.wb_read    = 1'b1;
            e.dirty_way  = vw;
            cycle(e);
            if (vd) wait_phase(PH_WB, dw, vw, src, suc);
        end

        wait_phase(PH_RREQ, dr, vw, src, suc);
        wait_phase(PH_RWAIT, dd, vw, src, suc);

        if (!suc && src == SRC_DW) begin
            noise();
            e           = base(1'b1);
            e.data_we   = 8'(1) << vw;
            e.use_way   = 8'(1) << vw;
            e.dirty_way = vw;
            e.dirty_set = 1'b1;
            cycle(e);
            merge_snap = snap;
        end
    endtask

    initial begin
        logic [1:0] rs;
        logic [7:0] rh;

        // Reset state, with a request presented while reset is held
        rstn      = 1'b0;
        req_valid = 1'b1;
        req_src   = SRC_IR;
        #3;
        chk("reset_outputs_zero", 64'(act), 64'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rstn      = 1'b1;
        @(posedge clk);
        #1;

        // dcache read hit on way 5
        idle(1);
        txn(SRC_DR, 1'b0, 8'b0010_0000, 3'd0, 1'b0, 0, 0, 0);
        chk("hit_dcache_ok", 64'(lk_snap.dc_ok), 64'h1);
        chk("hit_choose_way", 64'(lk_snap.choose_way), 64'h5);
        chk("hit_use_way", 64'(lk_snap.use_way), 64'h20);
        chk("hit_cnt_after_first", 64'(hit_cnt), 64'h1);

        // dcache write miss with dirty victim 3, writeback accepted after 4 cycles
        txn(SRC_DW, 1'b0, 8'h00, 3'd3, 1'b1, 4, 1, 2);
        chk("wmiss_refill_replace", 64'(refill_snap.data_replace), 64'h1);
        chk("wmiss_refill_we", 64'(refill_snap.data_we), 64'h08);
        chk("wmiss_merge_dirty_set", 64'(merge_snap.dirty_set), 64'h1);
        chk("wmiss_merge_dirty_way", 64'(merge_snap.dirty_way), 64'h3);
        chk("wmiss_miss_cnt", 64'(miss_cnt), 64'h1);

        // Strongly-ordered icache read: hit vector must be ignored
        txn(SRC_IR, 1'b1, 8'hFF, 3'd6, 1'b0, 0, 2, 3);
        chk("suc_lookup_use_way", 64'(lk_snap.use_way), 64'h0);
        chk("suc_icache_ok", 64'(refill_snap.ic_ok), 64'h1);
        chk("suc_no_array_write", 64'(refill_snap.data_we), 64'h0);
        chk("suc_hit_cnt_unchanged", 64'(hit_cnt), 64'h1);

        // Multi-hit: lowest way wins and the flag is sticky
        txn(SRC_IR, 1'b0, 8'b1001_0000, 3'd0, 1'b0, 0, 0, 0);
        chk("multihit_use_way", 64'(lk_snap.use_way), 64'h10);
        chk("multihit_choose_way", 64'(lk_snap.choose_way), 64'h4);
        chk("multihit_flag", 64'(err_multihit), 64'h1);
        txn(SRC_DW, 1'b0, 8'h01, 3'd0, 1'b0, 0, 0, 0);
        chk("multihit_sticky", 64'(err_multihit), 64'h1);

        // Refill address phase stalled past the watchdog limit
        txn(SRC_IR, 1'b0, 8'h00, 3'd2, 1'b0, 0, TMO + 3, 1);
        chk("timeout_flag", 64'(err_timeout), 64'h1);

        // Reset pulse in the middle of a refill
        exp_valid = 1'b0;
        req_valid = 1'b1;
        req_src   = SRC_IR;
        req_suc   = 1'b1;
        hit       = '0;
        {mem_addr_ok_r, mem_addr_ok_w, mem_data_ok} = 3'b000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_suc   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrefill_mem_req_r", 64'(mem_req_r), 64'h1);
        req_valid = 1'b1;
        rstn      = 1'b0;
        #1;
        chk("midrefill_reset_zero", 64'(act), 64'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rstn      = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_no_mem_req", 64'({mem_req_r, mem_req_w, busy}), 64'h0);
        hc_m = 0;
        mc_m = 0;
        mh_m = 1'b0;
        to_m = 1'b0;

        // Randomized traffic against the model
        for (int t = 0; t < 250; t++) begin
            case ($urandom_range(0, 2))
                0:       rs = SRC_IR;
                1:       rs = SRC_DR;
                default: rs = SRC_DW;
            endcase
            case ($urandom_range(0, 4))
                0, 1:    rh = 8'h00;
                2, 3:    rh = 8'(1) << $urandom_range(0, 7);
                default: rh = 8'($urandom);
            endcase
            idle($urandom_range(0, 2));
            txn(rs, ($urandom_range(0, 4) == 0), rh, 3'($urandom), 1'($urandom),
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
        end

        // Counter saturation
        for (int t = 0; t < CNT_MAX + 1; t++) begin
            txn(SRC_IR, 1'b0, 8'h02, 3'd0, 1'b0, 0, 0, 0);
            txn(SRC_DR, 1'b0, 8'h00, 3'd1, 1'b0, 0, 0, 0);
        end
        chk("hit_cnt_saturated", 64'(hit_cnt), 64'(CNT_MAX));
        chk("miss_cnt_saturated", 64'(miss_cnt), 64'(CNT_MAX));

        exp_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
